id_ex_pipe: RTL

Pipeline register between the ID stage (register-file read, decode) and the EX stage of the RISC-V core. It captures decoded operands and control fields each cycle and detects load-use hazards, stalling IF/ID and injecting a bubble when needed. It also precomputes the EX-stage forwarding selects one cycle early. A saturating bubble counter is provided for performance debug.

---
 rtl/id_ex_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, early forwarding-select
// computation and a saturating count of load-use bubbles.
module id_ex_pipe #(
  parameter int REG_DATA_WIDTH = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 64,
  parameter int CTRL_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [PC_WIDTH-1:0]       id_pc,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_DATA_WIDTH-1:0] id_rs1_data,
  input  logic [REG_DATA_WIDTH-1:0] id_rs2_data,
  input  logic [REG_DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                      flush,
  input  logic                      hold,
  output logic                      hazard_stall,
  output logic                      ex_valid,
  output logic [PC_WIDTH-1:0]       ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [REG_DATA_WIDTH-1:0] ex_rs1_data,
  output logic [REG_DATA_WIDTH-1:0] ex_rs2_data,
  output logic [REG_DATA_WIDTH-1:0] ex_imm,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic [1:0]                ex_fwd_a,
  output logic [1:0]                ex_fwd_b,
  output logic [31:0]               bubble_count
);

  typedef struct packed {
    logic                      valid;
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [REG_DATA_WIDTH-1:0] rs1_data;
    logic [REG_DATA_WIDTH-1:0] rs2_data;
    logic [REG_DATA_WIDTH-1:0] imm;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic [1:0]                fwd_a;
    logic [1:0]                fwd_b;
  } ex_stage_t;

  ex_stage_t ex_q;
  ex_stage_t id_entry;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;
  logic       ex_rd_nonzero;
  logic       mem_rd_nonzero;

  assign ex_rd_nonzero  = (ex_q.rd_addr != '0);
  assign mem_rd_nonzero = (mem_rd_addr != '0);

  always_comb begin
    hazard_stall = id_valid & ex_q.valid & ex_q.mem_read & ex_rd_nonzero &
                   ((id_use_rs1 & (id_rs1_addr == ex_q.rd_addr)) |
                    (id_use_rs2 & (id_rs2_addr == ex_q.rd_addr))) &
                   ~flush & ~hold;
  end

  // The instruction now in EX will sit in EX/MEM when this one reaches EX, so it takes precedence.
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (id_use_rs1) begin
      if (ex_q.valid & ex_q.reg_write & ex_rd_nonzero & (ex_q.rd_addr == id_rs1_addr))
        fwd_a_next = 2'b01;
      else if (mem_reg_write & mem_rd_nonzero & (mem_rd_addr == id_rs1_addr))
        fwd_a_next = 2'b10;
    end
    if (id_use_rs2) begin
      if (ex_q.valid & ex_q.reg_write & ex_rd_nonzero & (ex_q.rd_addr == id_rs2_addr))
        fwd_b_next = 2'b01;
      else if (mem_reg_write & mem_rd_nonzero & (mem_rd_addr == id_rs2_addr))
        fwd_b_next = 2'b10;
    end
  end

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.pc        = id_pc;
    id_entry.rs1_addr  = id_rs1_addr;
    id_entry.rs2_addr  = id_rs2_addr;
    id_entry.rd_addr   = id_rd_addr;
    id_entry.rs1_data  = id_rs1_data;
    id_entry.rs2_data  = id_rs2_data;
    id_entry.imm       = id_imm;
    id_entry.ctrl      = id_ctrl;
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
    id_entry.mem_write = id_mem_write;
    id_entry.fwd_a     = fwd_a_next;
    id_entry.fwd_b     = fwd_b_next;
  end

  // Flush beats hold; a bubble is an all-zero entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ex_q <= '0;
    else if (flush)
      ex_q <= '0;
    else if (hold)
      ex_q <= ex_q;
    else if (hazard_stall || !id_valid)
      ex_q <= '0;
    else
      ex_q <= id_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bubble_count <= '0;
    else if (hazard_stall && (bubble_count != 32'hFFFF_FFFF))
      bubble_count <= bubble_count + 32'd1;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_addr  = ex_q.rs1_addr;
  assign ex_rs2_addr  = ex_q.rs2_addr;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_fwd_a     = ex_q.fwd_a;
  assign ex_fwd_b     = ex_q.fwd_b;

endmodule
